// File: rtl/pipe_ifid_skid.sv
// IF/ID pipeline stage: main entry M plus an optional one-entry skid S, with a flush/stall
// interface and saturating stall/flush event counters for the performance monitor.
module pipe_ifid_skid #(
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned PC_W      = 16,
  parameter logic [15:0] NOP_INSTR = 16'b1100_0000_0000_0000,
  parameter bit          SKID      = 1'b1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
);

  localparam logic [INSTR_W-1:0] NopW = INSTR_W'(NOP_INSTR);

  logic               m_valid_q, m_valid_d;
  logic [INSTR_W-1:0] m_instr_q, m_instr_d;
  logic [PC_W-1:0]    m_pc_q, m_pc_d;
  logic               s_valid_q, s_valid_d;
  logic [INSTR_W-1:0] s_instr_q, s_instr_d;
  logic [PC_W-1:0]    s_pc_q, s_pc_d;
  logic               rdy_q;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               accept;

  // With the skid present, ready is a register image of !S.valid; otherwise it is combinational.
  assign in_ready_o = SKID ? rdy_q : (!stall_i || !m_valid_q);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    m_valid_d = m_valid_q;
    m_instr_d = m_instr_q;
    m_pc_d    = m_pc_q;
    s_valid_d = s_valid_q;
    s_instr_d = s_instr_q;
    s_pc_d    = s_pc_q;

    if (flush_i) begin
      m_valid_d = 1'b0;
      m_instr_d = NopW;
      s_valid_d = 1'b0;
    end else if (!stall_i) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_instr_d = s_instr_q;
        m_pc_d    = s_pc_q;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_instr_d = instr_i;
        m_pc_d    = pc_i;
      end else begin
        m_valid_d = 1'b0;
        m_instr_d = NopW;
      end
    end else if (accept) begin
      if (!m_valid_q) begin
        m_valid_d = 1'b1;
        m_instr_d = instr_i;
        m_pc_d    = pc_i;
      end else if (SKID) begin
        s_valid_d = 1'b1;
        s_instr_d = instr_i;
        s_pc_d    = pc_i;
      end
    end
    s_valid_d = s_valid_d && SKID;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_i && m_valid_q && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_i && (flush_cnt_q != '1))               flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q   <= 1'b0;
      m_instr_q   <= NopW;
      m_pc_q      <= '0;
      s_valid_q   <= 1'b0;
      s_instr_q   <= '0;
      s_pc_q      <= '0;
      rdy_q       <= 1'b1;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_instr_q   <= m_instr_d;
      m_pc_q      <= m_pc_d;
      s_valid_q   <= s_valid_d;
      s_instr_q   <= s_instr_d;
      s_pc_q      <= s_pc_d;
      rdy_q       <= !s_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign out_valid_o = m_valid_q;
  assign instr_o     = m_instr_q;
  assign pc_o        = m_pc_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ifid_skid.sv
// Bench for pipe_ifid_skid: a SKID=1 instance and a SKID=0/CNT_W=4 instance, each checked
// every cycle against a queue model of held instructions, plus directed literal checks.
module tb_pipe_ifid_skid;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rst_n;

  logic        in_valid [2];
  logic [15:0] instr [2];
  logic [15:0] pc [2];
  logic        stall [2];
  logic        flush [2];
  logic        rdy [2];
  logic        ov [2];
  logic [15:0] io [2];
  logic [15:0] po [2];
  logic [7:0]  sc0, fc0;
  logic [3:0]  sc1, fc1;

  pipe_ifid_skid #(.SKID(1'b1), .CNT_W(8)) u_skid (
    .clk_i(clk_i), .rst_n(rst_n), .in_valid_i(in_valid[0]), .in_ready_o(rdy[0]),
    .instr_i(instr[0]), .pc_i(pc[0]), .stall_i(stall[0]), .flush_i(flush[0]),
    .out_valid_o(ov[0]), .instr_o(io[0]), .pc_o(po[0]),
    .stall_cnt_o(sc0), .flush_cnt_o(fc0)
  );

  pipe_ifid_skid #(.SKID(1'b0), .CNT_W(4)) u_reg (
    .clk_i(clk_i), .rst_n(rst_n), .in_valid_i(in_valid[1]), .in_ready_o(rdy[1]),
    .instr_i(instr[1]), .pc_i(pc[1]), .stall_i(stall[1]), .flush_i(flush[1]),
    .out_valid_o(ov[1]), .instr_o(io[1]), .pc_o(po[1]),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );

  // Model: FIFO of held {instr,pc} entries (capacity 2 with skid, 1 without).
  int          n [2];
  logic [31:0] e [2][2];
  logic [15:0] pch [2];
  int          scnt [2];
  int          fcnt [2];
  int          cmax [2];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit model_ready(input int i);
    if (i == 0) return n[0] < 2;
    return !stall[1] || (n[1] == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      n[i] = 0; pch[i] = 16'h0; scnt[i] = 0; fcnt[i] = 0;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      bit acc;
      acc = in_valid[i] && model_ready(i);
      if (stall[i] && n[i] > 0 && scnt[i] < cmax[i]) scnt[i]++;
      if (flush[i]) begin
        if (fcnt[i] < cmax[i]) fcnt[i]++;
        n[i] = 0;
      end else begin
        if (!stall[i] && n[i] > 0) begin
          e[i][0] = e[i][1];
          n[i]--;
        end
        if (acc) begin
          e[i][n[i]] = {instr[i], pc[i]};
          n[i]++;
        end
      end
      if (n[i] > 0) pch[i] = e[i][0][15:0];
    end
  endtask

  task automatic compare_all();
    logic [7:0] gs [2];
    logic [7:0] gf [2];
    gs[0] = sc0; gf[0] = fc0;
    gs[1] = {4'h0, sc1}; gf[1] = {4'h0, fc1};
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d in_ready", i), 32'(rdy[i]), 32'(model_ready(i)));
      chk($sformatf("i%0d out_valid", i), 32'(ov[i]), 32'(n[i] > 0));
      chk($sformatf("i%0d instr", i), 32'(io[i]), n[i] > 0 ? 32'(e[i][0][31:16]) : 32'hC000);
      chk($sformatf("i%0d pc", i), 32'(po[i]), 32'(pch[i]));
      chk($sformatf("i%0d stall_cnt", i), 32'(gs[i]), 32'(scnt[i]));
      chk($sformatf("i%0d flush_cnt", i), 32'(gf[i]), 32'(fcnt[i]));
    end
  endtask

  task automatic set(input int i, input logic v, input logic [15:0] ins, input logic [15:0] p,
                     input logic st, input logic fl);
    in_valid[i] = v; instr[i] = ins; pc[i] = p; stall[i] = st; flush[i] = fl;
  endtask

  task automatic idle_all();
    set(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    set(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic step();
    #1;
    compare_all();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ov0"}, 32'(ov[0]), 32'h0);
    chk({tag, " io0"}, 32'(io[0]), 32'hC000);
    chk({tag, " po0"}, 32'(po[0]), 32'h0);
    chk({tag, " rdy0"}, 32'(rdy[0]), 32'h1);
    chk({tag, " cnt0"}, {16'(sc0), 16'(fc0)}, 32'h0);
    chk({tag, " ov1"}, 32'(ov[1]), 32'h0);
    chk({tag, " io1"}, 32'(io[1]), 32'hC000);
    chk({tag, " cnt1"}, {16'(sc1), 16'(fc1)}, 32'h0);
  endtask

  initial begin
    cmax[0] = 255; cmax[1] = 15;
    model_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_i);
    #1 chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk_i);
    step();

    // Unstalled stream through the skid instance.
    for (int k = 0; k < 4; k++) begin
      set(0, 1'b1, 16'h1001 + 16'(k), 16'(2 + 2 * k), 1'b0, 1'b0);
      step();
      chk("stream instr", 32'(io[0]), 32'h1001 + 32'(k));
      chk("stream pc", 32'(po[0]), 32'(2 + 2 * k));
    end
    idle_all();
    step();
    chk("stream end valid", 32'(ov[0]), 32'h0);
    chk("stream end nop", 32'(io[0]), 32'hC000);

    // Three stall cycles with a skid capture.
    set(0, 1'b1, 16'h1001, 16'd2, 1'b0, 1'b0); step();
    set(0, 1'b1, 16'h1002, 16'd4, 1'b1, 1'b0); step();
    chk("spill ready", 32'(rdy[0]), 32'h0);
    chk("spill hold M", 32'(io[0]), 32'h1001);
    set(0, 1'b1, 16'h1003, 16'd6, 1'b1, 1'b0); step(); step();
    chk("stall cnt 3", 32'(sc0), 32'd3);
    set(0, 1'b1, 16'h1003, 16'd6, 1'b0, 1'b0); step();
    chk("release S out", 32'(io[0]), 32'h1002);
    chk("release ready", 32'(rdy[0]), 32'h1);
    step();
    chk("after release", 32'(io[0]), 32'h1003);
    idle_all(); step();

    // Flush in SPILL with input valid, then flush with a real accept.
    set(0, 1'b1, 16'h2001, 16'd10, 1'b0, 1'b0); step();
    set(0, 1'b1, 16'h2002, 16'd12, 1'b1, 1'b0); step();
    set(0, 1'b1, 16'h2BAD, 16'd14, 1'b0, 1'b1); step();
    chk("flush valid", 32'(ov[0]), 32'h0);
    chk("flush nop", 32'(io[0]), 32'hC000);
    chk("flush pc held", 32'(po[0]), 32'd10);
    chk("flush ready", 32'(rdy[0]), 32'h1);
    chk("flush cnt", 32'(fc0), 32'h1);
    set(0, 1'b1, 16'h2BAD, 16'd16, 1'b0, 1'b1); step();
    chk("flush discard", 32'(ov[0]), 32'h0);
    idle_all(); step(); step();

    // Stall and flush together.
    set(0, 1'b1, 16'h3001, 16'd20, 1'b0, 1'b0); step();
    set(0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1); step();
    chk("stall+flush valid", 32'(ov[0]), 32'h0);
    chk("stall+flush ready", 32'(rdy[0]), 32'h1);
    idle_all(); step();

    // No-skid instance: combinational ready and 4-bit saturation.
    set(1, 1'b1, 16'h4001, 16'd30, 1'b0, 1'b0); step();
    for (int k = 0; k < 20; k++) begin
      set(1, 1'b1, 16'h4002, 16'd32, 1'b1, 1'b0);
      #1 chk("noskid ready stalled", 32'(rdy[1]), 32'h0);
      step();
    end
    chk("noskid sat", 32'(sc1), 32'd15);
    chk("noskid hold", 32'(io[1]), 32'h4001);
    set(1, 1'b1, 16'h4002, 16'd32, 1'b0, 1'b0);
    #1 chk("noskid ready free", 32'(rdy[1]), 32'h1);
    step();
    chk("noskid next", 32'(io[1]), 32'h4002);
    idle_all(); step();

    // Asynchronous reset while stalled in SPILL.
    set(0, 1'b1, 16'h5001, 16'd40, 1'b0, 1'b0); step();
    set(0, 1'b1, 16'h5002, 16'd42, 1'b1, 1'b0); step();
    set(0, 1'b1, 16'h5003, 16'd44, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async reset");
    model_reset();
    @(negedge clk_i);
    idle_all();
    rst_n = 1'b1;
    step();

    // Randomised traffic on both instances.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++)
        set(i, ($urandom % 4) != 0, 16'($urandom), 16'($urandom), ($urandom % 3) == 0,
            ($urandom % 20) == 0);
      step();
    end
    idle_all();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
